tdc_meas_ctrl: RTL and testbench

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_meas_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// ============================================================================
// tdc_meas_ctrl
// ----------------------------------------------------------------------------
// Measurement sequencer for a delay-line TDC. A run is started from IDLE with
// `start`. For every sample the controller:
//   SETUP   - drops launch/capture for one cycle so the TDC sees a fresh edge
//   LAUNCH  - raises tdc_clk_launch and holds it for gap_eff cycles
//   CAPTURE - raises tdc_clk_capture together with a one-cycle tdc_val_in
//   WAIT    - waits (bounded by TIMEOUT cycles) for tdc_val_out
//   ACCUM   - folds the captured Hamming weight into sum/min/max/count and
//             flips tdc_pg_tog
// When the requested number of samples has been accumulated, or a sample
// times out, the run ends in DONE with a one-cycle `done` pulse. Results stay
// on the outputs until the next accepted start.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   start                  run request, only looked at in IDLE
//   cfg_gap                launch-to-capture spacing in cycles (0 acts as 1)
//   cfg_nsamp              samples per run (0 acts as 256)
//   cfg_pg_src/_bypass/_in pulse-generator statics, latched at run start
//   tdc_clk_launch/capture launch and capture edges to the TDC
//   tdc_pg_src/_bypass/_in latched pulse-generator statics to the TDC
//   tdc_pg_tog             toggles once per accumulated sample
//   tdc_val_in             one-cycle sample strobe to the TDC
//   tdc_hw, tdc_val_out    TDC result and its valid flag
//   busy, done             run in progress / one-cycle end-of-run pulse
//   timeout_err            the run ended because a sample never came back
//   sum, min_hw, max_hw    accumulated statistics of the run
//   count                  number of accumulated samples (up to 256)
//
// Every output is a flop; the FSM writes the output values that belong to the
// state it is entering, so the outputs line up with the state register.
// ============================================================================
module tdc_meas_ctrl #(
    parameter int HW_W    = 7,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      cfg_gap,
    input  logic [7:0]      cfg_nsamp,
    input  logic            cfg_pg_src,
    input  logic            cfg_pg_bypass,
    input  logic            cfg_pg_in,
    output logic            tdc_clk_launch,
    output logic            tdc_clk_capture,
    output logic            tdc_pg_src,
    output logic            tdc_pg_bypass,
    output logic            tdc_pg_in,
    output logic            tdc_pg_tog,
    output logic            tdc_val_in,
    input  logic [HW_W-1:0] tdc_hw,
    input  logic            tdc_val_out,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [HW_W+7:0] sum,
    output logic [HW_W-1:0] min_hw,
    output logic [HW_W-1:0] max_hw,
    output logic [8:0]      count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_CAPTURE,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    // Last value of the WAIT counter before the sample is declared lost;
    // the counter starts at 0 on the first WAIT cycle, so WAIT lasts exactly
    // TIMEOUT cycles when no result arrives.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t          state_reg;
    logic [7:0]      gap_eff_reg;    // 1..255, latched at start
    logic [8:0]      nsamp_eff_reg;  // 1..256, latched at start
    logic [7:0]      phase_cnt_reg;  // LAUNCH length counter, reused as WAIT counter
    logic [HW_W-1:0] hw_reg;         // result captured in WAIT, consumed in ACCUM

    logic [8:0]      count_next;

    // Sample count after the current ACCUM; decides whether another sample
    // is needed without waiting for the count register to update.
    assign count_next = count + 9'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            gap_eff_reg     <= 8'd1;
            nsamp_eff_reg   <= 9'd1;
            phase_cnt_reg   <= 8'd0;
            hw_reg          <= '0;
            tdc_clk_launch  <= 1'b0;
            tdc_clk_capture <= 1'b0;
            tdc_pg_src      <= 1'b0;
            tdc_pg_bypass   <= 1'b0;
            tdc_pg_in       <= 1'b0;
            tdc_pg_tog      <= 1'b0;
            tdc_val_in      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            sum             <= '0;
            min_hw          <= '1;
            max_hw          <= '0;
            count           <= 9'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state_reg     <= S_SETUP;
                        busy          <= 1'b1;
                        gap_eff_reg   <= (cfg_gap == 8'd0) ? 8'd1 : cfg_gap;
                        nsamp_eff_reg <= (cfg_nsamp == 8'd0) ? 9'd256 : {1'b0, cfg_nsamp};
                        tdc_pg_src    <= cfg_pg_src;
                        tdc_pg_bypass <= cfg_pg_bypass;
                        tdc_pg_in     <= cfg_pg_in;
                        // Statistics of the previous run are only dropped now,
                        // so they stay readable while idle.
                        sum           <= '0;
                        count         <= 9'd0;
                        min_hw        <= '1;
                        max_hw        <= '0;
                        timeout_err   <= 1'b0;
                        tdc_clk_launch  <= 1'b0;
                        tdc_clk_capture <= 1'b0;
                        tdc_val_in      <= 1'b0;
                    end
                end

                S_SETUP: begin
                    state_reg      <= S_LAUNCH;
                    phase_cnt_reg  <= 8'd0;
                    tdc_clk_launch <= 1'b1;
                end

                S_LAUNCH: begin
                    if (phase_cnt_reg == gap_eff_reg - 8'd1) begin
                        state_reg       <= S_CAPTURE;
                        tdc_clk_capture <= 1'b1;
                        tdc_val_in      <= 1'b1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end

                S_CAPTURE: begin
                    state_reg     <= S_WAIT;
                    tdc_val_in    <= 1'b0;
                    phase_cnt_reg <= 8'd0;
                end

                S_WAIT: begin
                    // A result on the last allowed cycle still counts: the
                    // valid check has priority over the timeout check.
                    if (tdc_val_out) begin
                        state_reg       <= S_ACCUM;
                        hw_reg          <= tdc_hw;
                        tdc_clk_launch  <= 1'b0;
                        tdc_clk_capture <= 1'b0;
                    end else if (phase_cnt_reg == WAIT_LAST) begin
                        state_reg       <= S_DONE;
                        timeout_err     <= 1'b1;
                        done            <= 1'b1;
                        tdc_clk_launch  <= 1'b0;
                        tdc_clk_capture <= 1'b0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 8'd1;
                    end
                end

                S_ACCUM: begin
                    sum        <= sum + {8'd0, hw_reg};
                    count      <= count_next;
                    tdc_pg_tog <= ~tdc_pg_tog;
                    if (hw_reg < min_hw) begin
                        min_hw <= hw_reg;
                    end
                    if (hw_reg > max_hw) begin
                        max_hw <= hw_reg;
                    end
                    if (count_next < nsamp_eff_reg) begin
                        state_reg <= S_SETUP;
                    end else begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg       <= S_IDLE;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    tdc_clk_launch  <= 1'b0;
                    tdc_clk_capture <= 1'b0;
                    tdc_val_in      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// ============================================================================
// tb_tdc_meas_ctrl
// Bench for tdc_meas_ctrl. A run is described to a timeline builder that lays
// out, cycle by cycle, what every output must show for that run (SETUP, gap
// launch cycles, capture strobe, wait cycles, accumulate, done). A single
// driver process advances the clock, compares the DUT against the timeline
// (or against the held idle values) on every cycle, and adds literal checks
// after each directed run. A separate responder plays the TDC.
// ============================================================================
module tb_tdc_meas_ctrl;

    localparam int HW_W    = 7;
    localparam int TIMEOUT = 255;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [7:0]      cfg_gap;
    logic [7:0]      cfg_nsamp;
    logic            cfg_pg_src;
    logic            cfg_pg_bypass;
    logic            cfg_pg_in;
    logic            tdc_clk_launch;
    logic            tdc_clk_capture;
    logic            tdc_pg_src;
    logic            tdc_pg_bypass;
    logic            tdc_pg_in;
    logic            tdc_pg_tog;
    logic            tdc_val_in;
    logic [HW_W-1:0] tdc_hw;
    logic            tdc_val_out;
    logic            busy;
    logic            done;
    logic            timeout_err;
    logic [HW_W+7:0] sum;
    logic [HW_W-1:0] min_hw;
    logic [HW_W-1:0] max_hw;
    logic [8:0]      count;

    tdc_meas_ctrl #(.HW_W(HW_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_gap(cfg_gap), .cfg_nsamp(cfg_nsamp),
        .cfg_pg_src(cfg_pg_src), .cfg_pg_bypass(cfg_pg_bypass), .cfg_pg_in(cfg_pg_in),
        .tdc_clk_launch(tdc_clk_launch), .tdc_clk_capture(tdc_clk_capture),
        .tdc_pg_src(tdc_pg_src), .tdc_pg_bypass(tdc_pg_bypass), .tdc_pg_in(tdc_pg_in),
        .tdc_pg_tog(tdc_pg_tog), .tdc_val_in(tdc_val_in),
        .tdc_hw(tdc_hw), .tdc_val_out(tdc_val_out),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .sum(sum), .min_hw(min_hw), .max_hw(max_hw), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        launch;
        logic        capture;
        logic        val_in;
        logic        pg_src;
        logic        pg_bypass;
        logic        pg_in;
        logic        pg_tog;
        logic        busy;
        logic        done;
        logic        terr;
        logic [14:0] sum;
        logic [8:0]  count;
        logic [6:0]  min_hw;
        logic [6:0]  max_hw;
    } obs_t;

    // Per-sample TDC behaviour: latency (0 = never answers), result, and an
    // optional bogus valid during the capture cycle that must be ignored.
    int         lat_tab   [0:255];
    logic [6:0] hw_tab    [0:255];
    bit         early_tab [0:255];
    int         vin_total = 0;   // written by responder only
    int         resp_base = 0;   // written by driver only
    int         resp_idx;
    int         resp_lat;

    // Expected-output timeline (driver process only)
    obs_t tl [0:16383];
    int   wr = 0;
    int   rd = 0;
    int   flush_mark = 0;
    obs_t held;

    int   checks = 0;
    int   passed = 0;
    int   mon_launch = 0, mon_wait = 0, mon_done = 0, mon_tog = 0;
    int   s_launch, s_wait, s_done, s_tog;
    logic prev_tog = 1'b0;

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.min_hw = 7'h7f;
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.launch    = tdc_clk_launch;
        o.capture   = tdc_clk_capture;
        o.val_in    = tdc_val_in;
        o.pg_src    = tdc_pg_src;
        o.pg_bypass = tdc_pg_bypass;
        o.pg_in     = tdc_pg_in;
        o.pg_tog    = tdc_pg_tog;
        o.busy      = busy;
        o.done      = done;
        o.terr      = timeout_err;
        o.sum       = sum;
        o.count     = count;
        o.min_hw    = min_hw;
        o.max_hw    = max_hw;
        return o;
    endfunction

    task automatic push_tl(input obs_t o);
        if (wr < 16384) begin
            tl[wr] = o;
            wr++;
        end
    endtask

    // Lays out the whole run from the configuration and the TDC tables.
    task automatic build_run(input int g, input int n, input logic [2:0] pg);
        obs_t cur;
        cur = held;
        cur.busy = 1'b1; cur.done = 1'b0; cur.terr = 1'b0;
        cur.sum = '0; cur.count = '0; cur.min_hw = 7'h7f; cur.max_hw = '0;
        {cur.pg_src, cur.pg_bypass, cur.pg_in} = pg;
        cur.launch = 1'b0; cur.capture = 1'b0; cur.val_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_tl(cur);                                  // setup
            cur.launch = 1'b1;
            repeat (g) push_tl(cur);                       // launch-only cycles
            cur.capture = 1'b1; cur.val_in = 1'b1;
            push_tl(cur);                                  // capture strobe
            cur.val_in = 1'b0;
            if (lat_tab[i] == 0 || lat_tab[i] > TIMEOUT) begin
                repeat (TIMEOUT) push_tl(cur);             // wait until lost
                cur.terr = 1'b1;
                break;
            end
            repeat (lat_tab[i]) push_tl(cur);              // wait for result
            cur.launch = 1'b0; cur.capture = 1'b0;
            push_tl(cur);                                  // accumulate
            cur.sum    = cur.sum + 15'(hw_tab[i]);
            cur.count  = cur.count + 9'd1;
            if (hw_tab[i] < cur.min_hw) cur.min_hw = hw_tab[i];
            if (hw_tab[i] > cur.max_hw) cur.max_hw = hw_tab[i];
            cur.pg_tog = ~cur.pg_tog;
        end
        cur.launch = 1'b0; cur.capture = 1'b0; cur.done = 1'b1;
        push_tl(cur);                                      // done pulse
        cur.done = 1'b0; cur.busy = 1'b0;
        held = cur;
    endtask

    // One clock: compare on the falling edge, return 1 time unit after the
    // next rising edge so inputs change away from the active edge.
    task automatic step();
        obs_t act;
        obs_t exp;
        @(negedge clk);
        act = sample_dut();
        if (rd < flush_mark) rd = flush_mark;
        if (rd < wr) begin
            exp = tl[rd];
            rd++;
        end else begin
            exp = held;
        end
        checks++;
        if (act !== exp) $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, exp);
        else passed++;
        if (act.launch && !act.capture) mon_launch++;
        if (act.capture && !act.val_in) mon_wait++;
        if (act.done) mon_done++;
        if (act.pg_tog !== prev_tog) mon_tog++;
        prev_tog = act.pg_tog;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d want %0d", name, act, exp);
    endtask

    task automatic fill(input int lat, input logic [6:0] hw);
        for (int i = 0; i < 256; i++) begin
            lat_tab[i] = lat; hw_tab[i] = hw; early_tab[i] = 1'b0;
        end
    endtask

    task automatic run_meas(input logic [7:0] gap, input logic [7:0] ns, input logic [2:0] pg,
                            input int disturb_at, input int rst_after_vin);
        int geff, neff, cyc;
        geff = (gap == 8'd0) ? 1 : int'(gap);
        neff = (ns == 8'd0) ? 256 : int'(ns);
        cfg_gap = gap; cfg_nsamp = ns;
        {cfg_pg_src, cfg_pg_bypass, cfg_pg_in} = pg;
        s_launch = mon_launch; s_wait = mon_wait; s_done = mon_done; s_tog = mon_tog;
        resp_base = vin_total;
        start = 1'b1;
        step();
        start = 1'b0;
        build_run(geff, neff, pg);
        cyc = 0;
        while (rd < wr && cyc < 20000) begin
            if (disturb_at > 0 && cyc == disturb_at) begin
                start = 1'b1; cfg_gap = 8'd9; cfg_nsamp = 8'd7;
                {cfg_pg_src, cfg_pg_bypass, cfg_pg_in} = ~pg;
            end
            if (disturb_at > 0 && cyc == disturb_at + 3) start = 1'b0;
            step();
            cyc++;
            if (rst_after_vin > 0 && vin_total - resp_base >= rst_after_vin) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                flush_mark = wr;
                held = reset_obs();
                break;
            end
        end
        start = 1'b0;
    endtask

    // TDC responder
    initial begin
        tdc_val_out = 1'b0;
        tdc_hw = '0;
        forever begin
            @(negedge clk);
            if (tdc_val_in === 1'b1) begin
                resp_idx = vin_total - resp_base;
                vin_total++;
                if (resp_idx < 0 || resp_idx > 255) resp_idx = 0;
                resp_lat = lat_tab[resp_idx];
                if (early_tab[resp_idx]) begin
                    tdc_val_out = 1'b1; tdc_hw = 7'h55;
                end
                @(posedge clk); #1;
                tdc_val_out = 1'b0;
                if (resp_lat > 0) begin
                    repeat (resp_lat - 1) begin
                        @(posedge clk); #1;
                    end
                    tdc_val_out = 1'b1; tdc_hw = hw_tab[resp_idx];
                    @(posedge clk); #1;
                    tdc_val_out = 1'b0; tdc_hw = 7'($urandom);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_gap = '0; cfg_nsamp = '0;
        cfg_pg_src = 1'b0; cfg_pg_bypass = 1'b0; cfg_pg_in = 1'b0;
        held = reset_obs();
        fill(1, 7'd0);
        @(posedge clk); #1;
        repeat (3) step();                      // reset values while held in reset
        rst_n = 1'b1;
        repeat (2) step();

        // Four samples, mixed latencies, bogus valid during capture of sample 1
        fill(1, 7'd0);
        hw_tab[0] = 7'd10; hw_tab[1] = 7'd20; hw_tab[2] = 7'd5; hw_tab[3] = 7'd63;
        lat_tab[0] = 1; lat_tab[1] = 3; lat_tab[2] = 2; lat_tab[3] = 4;
        early_tab[1] = 1'b1;
        run_meas(8'd2, 8'd4, 3'b010, 0, 0);
        $display("run nsamp=4: sum=%0d min=%0d max=%0d count=%0d", sum, min_hw, max_hw, count);
        chk("sum4", int'(sum), 98);
        chk("min4", int'(min_hw), 5);
        chk("max4", int'(max_hw), 63);
        chk("count4", int'(count), 4);
        chk("tog_flips4", mon_tog - s_tog, 4);
        chk("tog_end4", int'(tdc_pg_tog), 0);
        chk("model_sum4", int'(held.sum), 98);

        // Single sample, gap 3, result 37 two cycles after the strobe
        fill(2, 7'd37);
        run_meas(8'd3, 8'd1, 3'b101, 0, 0);
        $display("run gap=3: sum=%0d launch_only=%0d done=%0d", sum, mon_launch - s_launch, mon_done - s_done);
        chk("launch_cycles1", mon_launch - s_launch, 3);
        chk("sum1", int'(sum), 37);
        chk("min1", int'(min_hw), 37);
        chk("max1", int'(max_hw), 37);
        chk("count1", int'(count), 1);
        chk("done_pulses1", mon_done - s_done, 1);
        chk("model_count1", int'(held.count), 1);

        // TDC never answers
        fill(0, 7'd0);
        run_meas(8'd1, 8'd3, 3'b000, 0, 0);
        $display("run timeout: terr=%0d wait_cycles=%0d count=%0d", timeout_err, mon_wait - s_wait, count);
        chk("terr", int'(timeout_err), 1);
        chk("wait_cycles", mon_wait - s_wait, 255);
        chk("count_to", int'(count), 0);
        chk("sum_to", int'(sum), 0);
        chk("done_pulses_to", mon_done - s_done, 1);
        chk("model_terr", int'(held.terr), 1);

        // Result on the very last allowed wait cycle is still accepted
        fill(255, 7'd99);
        run_meas(8'd1, 8'd1, 3'b001, 0, 0);
        $display("run last-cycle result: terr=%0d sum=%0d", timeout_err, sum);
        chk("terr_edge", int'(timeout_err), 0);
        chk("sum_edge", int'(sum), 99);

        // Reset during the wait of sample 2
        fill(3, 7'd7);
        lat_tab[1] = 20;
        run_meas(8'd2, 8'd3, 3'b111, 0, 2);
        $display("run reset-abort: busy=%0d count=%0d sum=%0d", busy, count, sum);
        chk("done_pulses_rst", mon_done - s_done, 0);
        chk("count_rst", int'(count), 0);
        chk("sum_rst", int'(sum), 0);
        chk("busy_rst", int'(busy), 0);
        repeat (30) step();                     // late TDC answer arrives while idle
        chk("done_after_rst", mon_done - s_done, 0);

        fill(2, 7'd1);
        hw_tab[1] = 7'd2;
        run_meas(8'd1, 8'd2, 3'b100, 0, 0);
        $display("run after reset: sum=%0d count=%0d", sum, count);
        chk("sum_post_rst", int'(sum), 3);
        chk("count_post_rst", int'(count), 2);

        // Zero configuration means gap 1 and 256 samples
        fill(1, 7'd127);
        run_meas(8'd0, 8'd0, 3'b011, 0, 0);
        $display("run zero cfg: sum=%0d count=%0d launch_only=%0d", sum, count, mon_launch - s_launch);
        chk("sum256", int'(sum), 32512);
        chk("count256", int'(count), 256);
        chk("launch256", mon_launch - s_launch, 256);
        chk("max256", int'(max_hw), 127);
        chk("min256", int'(min_hw), 127);

        // Start and configuration poked while busy
        fill(2, 7'd4);
        run_meas(8'd2, 8'd3, 3'b110, 5, 0);
        repeat (10) step();
        $display("run busy-poke: count=%0d done=%0d busy=%0d", count, mon_done - s_done, busy);
        chk("done_pulses_poke", mon_done - s_done, 1);
        chk("count_poke", int'(count), 3);
        chk("launch_poke", mon_launch - s_launch, 6);
        chk("sum_poke", int'(sum), 12);
        chk("busy_poke", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
